// File: rtl/rr_onehot_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner signals done, withdraws its request, or
// the hold counter expires. At least one idle cycle separates grants, so
// the grant vector is always 4'b0000 or exactly one-hot.
module rr_onehot_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [1:0] owner
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last hold-count value before a forced release.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic          timeout_q, timeout_d;
  logic          gnt_valid_q, gnt_valid_d;

  logic          win_found_s;
  logic [1:0]    win_idx_s;
  logic [1:0]    cand_s;
  logic          release_s;
  logic          expire_s;

  // Binary index to one-hot code; the only way a grant vector is formed.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] code;
    code = 4'b0001 << idx;
    return code;
  endfunction

  // Round-robin search: first set request starting at ptr and wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = 2'd0;
    cand_s      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand_s = ptr_q + 2'(i);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Release qualification: done/withdrawal wins over expiry, so a
  // simultaneous expiry is a normal release without a timeout pulse.
  always_comb begin
    release_s = done || !req[owner_q];
    expire_s  = !release_s && (cnt_q >= CNT_LAST);
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    timeout_d   = 1'b0;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (win_found_s) begin
          state_d     = GRANT;
          gnt_d       = onehot4(win_idx_s);
          owner_d     = win_idx_s;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = 4'b0000;
          owner_d     = 2'd0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s || expire_s) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          owner_d     = 2'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = {CW{1'b0}};
          ptr_d       = owner_q + 2'd1;
          timeout_d   = expire_s;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 4'b0000;
        owner_d     = 2'd0;
        gnt_valid_d = 1'b0;
        cnt_d       = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      cnt_q       <= {CW{1'b0}};
      gnt_q       <= 4'b0000;
      owner_q     <= 2'd0;
      timeout_q   <= 1'b0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: stimulus pushes the expected
// grant episodes (code, owner, visible length, timeout pulse) and a
// monitor pops one whenever a grant ends.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] owner;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [7:0] len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];

  rr_onehot_arbiter #(.TIMEOUT(15), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .owner     (owner)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] o,
                      input logic [7:0] l, input logic t);
    exp_t e;
    e.gnt = g; e.owner = o; e.len = l; e.to = t;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One grant with done raised the cycle after it appears.
  task automatic grant_done();
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, tracks each grant episode.
  logic [3:0] prev_gnt = 4'b0000;
  logic [7:0] run_len  = 8'd0;
  logic [1:0] run_own  = 2'd0;
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (!(gnt == 4'b0000 || gnt == 4'b0001 || gnt == 4'b0010 ||
          gnt == 4'b0100 || gnt == 4'b1000) || (gnt_valid !== (gnt != 4'b0000))) begin
      failures++;
      $display("FAIL onehot: gnt=%b gnt_valid=%b", gnt, gnt_valid);
    end
    if (gnt != 4'b0000) begin
      if (prev_gnt == 4'b0000) begin
        run_len = 8'd1;
        run_own = owner;
      end else begin
        run_len = run_len + 8'd1;
        checks++;
        if (gnt !== prev_gnt) begin
          failures++;
          $display("FAIL hold: gnt=%b changed from %b", gnt, prev_gnt);
        end
      end
      checks++;
      if (timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_during_grant: got %b expected 0", timeout);
      end
    end else if (prev_gnt != 4'b0000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_grant: gnt=%b len=%0d", prev_gnt, run_len);
      end else begin
        e = exp_q.pop_front();
        if (prev_gnt !== e.gnt || run_own !== e.owner || run_len !== e.len ||
            timeout !== e.to || owner !== 2'd0) begin
          failures++;
          $display("FAIL grant_episode: got gnt=%b owner=%0d len=%0d to=%b idle_owner=%0d expected gnt=%b owner=%0d len=%0d to=%b idle_owner=0",
                   prev_gnt, run_own, run_len, timeout, owner, e.gnt, e.owner, e.len, e.to);
        end
      end
    end else begin
      checks++;
      if (timeout !== 1'b0 || owner !== 2'd0) begin
        failures++;
        $display("FAIL idle_outputs: timeout=%b owner=%0d expected 0 0", timeout, owner);
      end
    end
    prev_gnt = gnt;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    cyc(2);
    chk("reset_gnt", {4'b0000, gnt}, 8'h00);
    chk("reset_valid", {7'd0, gnt_valid}, 8'h00);
    chk("reset_timeout", {7'd0, timeout}, 8'h00);
    chk("reset_owner", {6'd0, owner}, 8'h00);
    rst = 1'b0;

    // req 0101 alternates between requesters 0 and 2.
    req = 4'b0101;
    push(4'b0001, 2'd0, 8'd1, 1'b0);
    push(4'b0100, 2'd2, 8'd1, 1'b0);
    push(4'b0001, 2'd0, 8'd1, 1'b0);
    push(4'b0100, 2'd2, 8'd1, 1'b0);
    repeat (4) grant_done();
    req = 4'b0000;
    cyc(1);

    // Full rotation from ptr 0, wrapping 3 -> 0.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b1111;
    push(4'b0001, 2'd0, 8'd1, 1'b0);
    push(4'b0010, 2'd1, 8'd1, 1'b0);
    push(4'b0100, 2'd2, 8'd1, 1'b0);
    push(4'b1000, 2'd3, 8'd1, 1'b0);
    push(4'b0001, 2'd0, 8'd1, 1'b0);
    repeat (5) grant_done();
    req = 4'b0000;
    cyc(1);

    // Forced release after 15 cycles, then regrant after one idle cycle.
    req = 4'b0010;
    push(4'b0010, 2'd1, 8'd15, 1'b1);
    push(4'b0010, 2'd1, 8'd1, 1'b0);
    cyc(1);
    cyc(15);
    chk("timeout_pulse", {7'd0, timeout}, 8'h01);
    grant_done();
    req = 4'b0000;
    cyc(1);

    // Owner 1 releases with done on its expiry cycle; ptr becomes 2.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    req = 4'b0010;
    push(4'b0010, 2'd1, 8'd15, 1'b0);
    push(4'b0100, 2'd2, 8'd1, 1'b0);
    cyc(1);
    cyc(14);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    chk("expiry_done_no_timeout", {7'd0, timeout}, 8'h00);
    req = 4'b0111;
    grant_done();
    req = 4'b0000;
    cyc(1);

    // Owner 3 withdraws; search resumes from ptr 0.
    req = 4'b1011;
    push(4'b1000, 2'd3, 8'd1, 1'b0);
    push(4'b0001, 2'd0, 8'd1, 1'b0);
    cyc(1);
    req = 4'b0011;
    cyc(1);
    grant_done();
    req = 4'b0000;
    cyc(1);

    // Reset in the middle of a grant.
    req = 4'b1000;
    push(4'b1000, 2'd3, 8'd4, 1'b0);
    push(4'b1000, 2'd3, 8'd1, 1'b0);
    cyc(1);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midreset_gnt", {4'b0000, gnt}, 8'h00);
    chk("midreset_timeout", {7'd0, timeout}, 8'h00);
    chk("midreset_ptr", {6'd0, dut.ptr_q}, 8'h00);
    cyc(1);
    chk("post_reset_regrant", {4'b0000, gnt}, 8'h08);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    req = 4'b0000;
    cyc(3);

    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
